heu_win_rx: RTL and testbench
=============================

# heu_win_rx

Receiving end of the IPGU→HEU window interface. The block accepts complete 20×20 8-bit pixel windows (400 bytes, five 80-byte chunks) from the IPGU using the `vldIpgu`/`rdyHeu` handshake and holds them in a two-slot ping-pong buffer. It then streams each window to the HEU datapath as 20 rows of 20 pixels over a valid/ready interface. It also produces per-window min/max statistics for the equalization stage.

## Interface
- `ROWS`, 20: window rows; also pixels per row.
- `CNT_W`, 16: width of the window counter.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `vldIpgu` in 1: IPGU window valid.
- `ipguOutBufferQ` in [4:0][79:0][7:0]: window data. Pixel k (row-major, row = k/20, col = k%20) is `ipguOutBufferQ[k/80][k%80]`.
- `rdyHeu` out 1: a window slot is free; the window is accepted on the edge where `vldIpgu && rdyHeu`.
- `rdyHeuRow` in 1: downstream ready for a row.
- `vldHeuRow` out 1: `heuRowQ` is valid.
- `heuRowQ` out [19:0][7:0]: current row. Element c is column c.
- `rowIdx` out 5: row number of `heuRowQ`, 0..19.
- `lastRow` out 1: `vldHeuRow && rowIdx==19`.
- `winMin`, `winMax` out 8 each: statistics of the most recently completed window.
- `winStatsVld` out 1: one-cycle pulse when `winMin`/`winMax` update.
- `winCnt` out CNT_W: number of windows fully streamed out; wraps modulo 2^CNT_W.

## Operation
- Storage: two 400-byte slots `buf[0..1]`, plus registers `wrPtr`, `rdPtr` (1 bit each), `count` (0..2) and `rowCnt` (0..19).
- `rdyHeu = (count != 2)`. It is combinational from registers only and never depends on `vldIpgu`.
- Accept:
  - When `vldIpgu && rdyHeu`, all 400 bytes are written into `buf[wrPtr]` in one edge.
  - `wrPtr` toggles on the same edge.
- Output:
  - `vldHeuRow = (count != 0)`.
  - `heuRowQ` = `buf[rdPtr]` pixels 20·rowCnt .. 20·rowCnt+19.
  - `rowIdx = rowCnt`.
- Row handshake (`vldHeuRow && rdyHeuRow`):
  - If rowCnt < 19: rowCnt increments.
  - If rowCnt == 19: rowCnt→0, `rdPtr` toggles and the slot is freed.
- Count update on each edge:
  - Accept and free on the same edge: `count` is unchanged.
  - Accept only: `count + 1`.
  - Free only: `count − 1`.
  - An accept when `count == 2` is impossible because `rdyHeu` is 0.
- Output registers hold while `rdyHeuRow` is low. `heuRowQ`, `rowIdx` and `lastRow` are stable until the handshake.
- Statistics:
  - Running accumulators `accMin` (init 0xFF) and `accMax` (init 0x00) fold in the combinational min/max of `heuRowQ` on every row handshake.
  - On the row-19 handshake: `winMin <= min(accMin, rowMin)`, `winMax <= max(accMax, rowMax)`, the accumulators reinitialise, `winCnt` increments and `winStatsVld` is 1 in the next cycle only.
- Unsigned 8-bit compares. `winCnt` wraps from 2^CNT_W−1 to 0.

## Timing
- Reset values:
  - `count=0`, `wrPtr=rdPtr=0`, `rowCnt=0`.
  - `rdyHeu=1`, `vldHeuRow=0`, `lastRow=0`, `rowIdx=0`.
  - `winMin=0xFF`, `winMax=0x00`, `winStatsVld=0`, `winCnt=0`.
  - `heuRowQ=0`: buffer contents are cleared on reset.
- Latency:
  - A window accepted into an empty block at edge N presents row 0 with `vldHeuRow=1` in cycle N+1.
  - Row 19 is presented at cycle N+20 at the earliest with `rdyHeuRow` held high.
  - `winStatsVld` pulses in cycle N+21.
- Throughput: one row per cycle. Back-to-back windows stream with no bubble when the second slot is filled before row 19 of the first window is taken.
- Full-buffer release: with `count == 2`, `rdyHeu` rises in the cycle after the row-19 handshake.
- Reset mid-operation (asynchronous):
  - Both slots are discarded and any partially streamed window is lost.
  - Accumulators and `winCnt` clear; no `winStatsVld` pulse is produced.
- `vldIpgu` may drop without acceptance. The block imposes no hold requirement.

## Test plan
- Ramp window (pixel k = k mod 256), `rdyHeuRow=1`, accepted at cycle 5:
  - rows 0..19 appear in cycles 6..25, with row r column c = (20r+c) mod 256;
  - `lastRow` high at cycle 25;
  - `winStatsVld` at cycle 26 with `winMin=0x00`, `winMax=0xFF`, `winCnt=1`.
- Three windows offered back-to-back (constant fills 0x11, 0x22, 0x33), `rdyHeuRow=0`:
  - the first two are accepted and `rdyHeu` falls to 0;
  - after releasing `rdyHeuRow`, `rdyHeu` rises the cycle after the first window's row-19 handshake;
  - outputs arrive in order 0x11, 0x22, 0x33, with `winMin=winMax` equal to each fill.
- Random `rdyHeuRow` stalls (50%):
  - `heuRowQ`/`rowIdx` stay stable while stalled;
  - each row is delivered exactly once;
  - the data matches a scoreboard.
- Simultaneous accept and free (`count=1`, row-19 handshake on the same edge as a new accept):
  - `count` stays 1;
  - the next cycle presents row 0 of the new window.
- Window with one pixel at 0x03 (row 7) and one at 0xF0 (row 19), all other pixels 0x80:
  - `winMin=0x03`, `winMax=0xF0`.
- Assert `rst_n` low at row 10 of a stream:
  - all outputs immediately take their reset values, with `winCnt=0`;
  - a new window after reset streams correctly from row 0.

Source files
------------

// File: rtl/heu_win_rx.sv
// heu_win_rx: receive side of the IPGU->HEU window link.
// Whole 20x20 windows are captured in one edge into a two-slot ping-pong
// store, then replayed one 20-pixel row per handshake towards the HEU.
// Per-window min/max is accumulated as rows leave the block.
//
// Handshake rules (both interfaces): a transfer happens on the rising edge
// where valid && ready are both 1. Valid/data hold until taken. rdyHeu and
// vldHeuRow are derived from registers only and never look at the peer's
// valid/ready input.
module heu_win_rx #(
    parameter int ROWS  = 20,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vldIpgu,
    input  logic [4:0][79:0][7:0]  ipguOutBufferQ,
    output logic                   rdyHeu,
    input  logic                   rdyHeuRow,
    output logic                   vldHeuRow,
    output logic [19:0][7:0]       heuRowQ,
    output logic [4:0]             rowIdx,
    output logic                   lastRow,
    output logic [7:0]             winMin,
    output logic [7:0]             winMax,
    output logic                   winStatsVld,
    output logic [CNT_W-1:0]       winCnt
);

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    // Chunked input viewed as a flat row-major pixel array: pixel k lands at
    // index k because chunk c / byte b sits at bit offset (80*c + b) * 8.
    logic [399:0][7:0]      winFlat;
    logic [1:0][399:0][7:0] slotMem;
    logic                   wrPtr;
    logic                   rdPtr;
    logic [1:0]             count;
    logic [4:0]             rowCnt;
    logic [8:0]             rowBase;
    logic [7:0]             accMin;
    logic [7:0]             accMax;
    logic [7:0]             rowMin;
    logic [7:0]             rowMax;
    logic [7:0]             foldMin;
    logic [7:0]             foldMax;
    logic                   accept;
    logic                   rowHs;
    logic                   winDone;

    assign winFlat   = ipguOutBufferQ;
    assign rdyHeu    = (count != 2'd2);
    assign vldHeuRow = (count != 2'd0);
    assign rowIdx    = rowCnt;
    assign lastRow   = vldHeuRow && (rowCnt == LAST_ROW);
    assign rowBase   = 9'(rowCnt) * 9'd20;
    // The slot being read is never the slot being written while it is
    // presented (count==1 implies wrPtr != rdPtr), so the row stays stable
    // across stalls without a separate output register.
    assign heuRowQ   = slotMem[rdPtr][rowBase +: 20];

    assign accept  = vldIpgu && rdyHeu;
    assign rowHs   = vldHeuRow && rdyHeuRow;
    assign winDone = rowHs && (rowCnt == LAST_ROW);

    // Min/max of the row currently presented, folded with the running values.
    always_comb begin
        rowMin = 8'hFF;
        rowMax = 8'h00;
        for (int c = 0; c < 20; c++) begin
            if (heuRowQ[c] < rowMin) rowMin = heuRowQ[c];
            if (heuRowQ[c] > rowMax) rowMax = heuRowQ[c];
        end
        foldMin = (rowMin < accMin) ? rowMin : accMin;
        foldMax = (rowMax > accMax) ? rowMax : accMax;
    end

    // Window capture: the whole 400-byte window is written into the free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotMem <= '0;
        end else if (accept) begin
            slotMem[wrPtr] <= winFlat;
        end
    end

    // Slot bookkeeping: pointers, occupancy and row position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            count  <= 2'd0;
            rowCnt <= 5'd0;
        end else begin
            if (accept) wrPtr <= ~wrPtr;
            if (rowHs) begin
                if (winDone) begin
                    rowCnt <= 5'd0;
                    rdPtr  <= ~rdPtr;
                end else begin
                    rowCnt <= rowCnt + 5'd1;
                end
            end
            if (accept && !winDone) begin
                count <= count + 2'd1;
            end else if (!accept && winDone) begin
                count <= count - 2'd1;
            end
        end
    end

    // Per-window statistics, published with a one-cycle pulse after row 19.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accMin      <= 8'hFF;
            accMax      <= 8'h00;
            winMin      <= 8'hFF;
            winMax      <= 8'h00;
            winStatsVld <= 1'b0;
            winCnt      <= '0;
        end else begin
            winStatsVld <= winDone;
            if (rowHs) begin
                if (winDone) begin
                    winMin <= foldMin;
                    winMax <= foldMax;
                    accMin <= 8'hFF;
                    accMax <= 8'h00;
                    winCnt <= winCnt + CNT_W'(1);
                end else begin
                    accMin <= foldMin;
                    accMax <= foldMax;
                end
            end
        end
    end

endmodule

// File: tb/tb_heu_win_rx.sv
// tb_heu_win_rx: randomized and directed bench for heu_win_rx.
// The reference model keeps the expected rows of accepted windows in a FIFO
// and each window's min/max in a second FIFO; all DUT outputs are predicted
// from those queues every cycle.
module tb_heu_win_rx;

  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  vldIpgu = 1'b0;
  logic [4:0][79:0][7:0] ipguOutBufferQ = '0;
  logic                  rdyHeu;
  logic                  rdyHeuRow = 1'b0;
  logic                  vldHeuRow;
  logic [19:0][7:0]      heuRowQ;
  logic [4:0]            rowIdx;
  logic                  lastRow;
  logic [7:0]            winMin;
  logic [7:0]            winMax;
  logic                  winStatsVld;
  logic [CNT_W-1:0]      winCnt;

  heu_win_rx #(.ROWS(20), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .vldIpgu(vldIpgu), .ipguOutBufferQ(ipguOutBufferQ),
    .rdyHeu(rdyHeu), .rdyHeuRow(rdyHeuRow), .vldHeuRow(vldHeuRow), .heuRowQ(heuRowQ),
    .rowIdx(rowIdx), .lastRow(lastRow), .winMin(winMin), .winMax(winMax),
    .winStatsVld(winStatsVld), .winCnt(winCnt)
  );

  // clock
  always #5 clk = ~clk;

  // reference model state
  logic [159:0]     exp_q[$];
  logic [15:0]      stat_q[$];
  logic [7:0]       m_min = 8'hFF;
  logic [7:0]       m_max = 8'h00;
  logic             m_stats_vld = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [159:0] get_row(input logic [3199:0] w, input int r);
    return w[r*160 +: 160];
  endfunction

  function automatic logic [15:0] win_stats(input logic [3199:0] w);
    logic [7:0] mn = 8'hFF;
    logic [7:0] mx = 8'h00;
    for (int k = 0; k < 400; k++) begin
      if (w[k*8 +: 8] < mn) mn = w[k*8 +: 8];
      if (w[k*8 +: 8] > mx) mx = w[k*8 +: 8];
    end
    return {mn, mx};
  endfunction

  function automatic logic [3199:0] fill_win(input logic [7:0] b);
    logic [3199:0] w;
    for (int k = 0; k < 400; k++) w[k*8 +: 8] = b;
    return w;
  endfunction

  function automatic logic [3199:0] rand_win();
    logic [3199:0] w;
    for (int k = 0; k < 400; k++) w[k*8 +: 8] = 8'($urandom);
    return w;
  endfunction

  function automatic logic [3199:0] ramp_win();
    logic [3199:0] w;
    for (int k = 0; k < 400; k++) w[k*8 +: 8] = 8'(k);
    return w;
  endfunction

  function automatic int m_windows();
    return (exp_q.size() + 19) / 20;
  endfunction

  function automatic int m_rowidx();
    int s = exp_q.size();
    if (s == 0) return 0;
    return 20 - (((s - 1) % 20) + 1);
  endfunction

  task automatic check_outputs();
    check("rdyHeu", 160'(rdyHeu), 160'(m_windows() < 2));
    check("vldHeuRow", 160'(vldHeuRow), 160'(exp_q.size() != 0));
    check("rowIdx", 160'(rowIdx), 160'(m_rowidx()));
    check("lastRow", 160'(lastRow), 160'(exp_q.size() != 0 && m_rowidx() == 19));
    if (exp_q.size() != 0) check("heuRowQ", heuRowQ, exp_q[0]);
    check("winMin", 160'(winMin), 160'(m_min));
    check("winMax", 160'(winMax), 160'(m_max));
    check("winStatsVld", 160'(winStatsVld), 160'(m_stats_vld));
    check("winCnt", 160'(winCnt), 160'(m_cnt));
  endtask

  // driver: apply inputs for one cycle, advance model across the edge, check
  task automatic step(input logic vld, input logic [3199:0] win, input logic rdy_row,
                      output logic accepted);
    logic acc;
    logic hs;
    logic last;
    vldIpgu = vld;
    ipguOutBufferQ = win;
    rdyHeuRow = rdy_row;
    acc  = vld && (m_windows() < 2);
    hs   = rdy_row && (exp_q.size() != 0);
    last = hs && (m_rowidx() == 19);
    @(posedge clk);
    #1;
    if (hs) void'(exp_q.pop_front());
    m_stats_vld = 1'b0;
    if (last) begin
      {m_min, m_max} = stat_q.pop_front();
      m_stats_vld = 1'b1;
      m_cnt = m_cnt + 1'b1;
    end
    if (acc) begin
      for (int r = 0; r < 20; r++) exp_q.push_back(get_row(win, r));
      stat_q.push_back(win_stats(win));
    end
    accepted = acc;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic rdy_row);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy_row, a);
  endtask

  task automatic offer(input logic [3199:0] win, input logic rdy_row);
    logic a = 1'b0;
    int g = 0;
    while (!a && g < 100) begin
      step(1'b1, win, rdy_row, a);
      g++;
    end
    check("offer_accepted", 160'(a), 160'(1));
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      idle(1, 1'b1);
      g++;
    end
    check("drain_empty", 160'(exp_q.size()), 160'(0));
    idle(2, 1'b1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    stat_q.delete();
    m_min = 8'hFF;
    m_max = 8'h00;
    m_stats_vld = 1'b0;
    m_cnt = '0;
  endtask

  logic [3199:0] w_a;
  logic [3199:0] w_b;
  logic          acc_flag;
  int            guard;

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("reset_heuRowQ", heuRowQ, 160'(0));
    rst_n = 1'b1;

    // ramp window accepted at cycle 5, free-flowing downstream
    idle(4, 1'b1);
    offer(ramp_win(), 1'b1);
    check("ramp_row0_c1", 160'(heuRowQ[1]), 160'(1));
    idle(19, 1'b1);
    check("ramp_last", 160'(lastRow), 160'(1));
    idle(1, 1'b1);
    check("ramp_stats_vld", 160'(winStatsVld), 160'(1));
    check("ramp_min_max", 160'({winMin, winMax}), 160'(16'h00FF));
    idle(2, 1'b1);

    // three constant windows against a stalled downstream
    step(1'b1, fill_win(8'h11), 1'b0, acc_flag);
    step(1'b1, fill_win(8'h22), 1'b0, acc_flag);
    check("full_rdy_low", 160'(rdyHeu), 160'(0));
    idle(3, 1'b0);
    offer(fill_win(8'h33), 1'b1);
    drain();

    // isolated extremes in rows 7 and 19
    w_a = fill_win(8'h80);
    w_a[(7*20+3)*8 +: 8] = 8'h03;
    w_a[(19*20+11)*8 +: 8] = 8'hF0;
    offer(w_a, 1'b1);
    drain();
    check("extreme_min_max", 160'({winMin, winMax}), 160'(16'h03F0));

    // accept and free on the same edge
    w_a = rand_win();
    w_b = rand_win();
    offer(w_a, 1'b0);
    guard = 0;
    while (m_rowidx() != 19 && guard < 40) begin
      idle(1, 1'b1);
      guard++;
    end
    step(1'b1, w_b, 1'b1, acc_flag);
    check("simul_accept", 160'(acc_flag), 160'(1));
    check("simul_row0", heuRowQ, get_row(w_b, 0));
    check("simul_rowIdx", 160'(rowIdx), 160'(0));
    drain();

    // randomized traffic with 50% downstream stalls
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), rand_win(), 1'($urandom_range(0, 1)), acc_flag);
    end
    drain();

    // asynchronous reset in the middle of a window
    offer(rand_win(), 1'b1);
    guard = 0;
    while (m_rowidx() != 10 && guard < 40) begin
      idle(1, 1'b1);
      guard++;
    end
    rdyHeuRow = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("midreset_heuRowQ", heuRowQ, 160'(0));
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    offer(ramp_win(), 1'b1);
    check("post_reset_row0", 160'(rowIdx), 160'(0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
